// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } arb_state_e;

   localparam int STAT_W = 16;

   // Never returns 0 so that single-entry cases still get a legal vector width.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request after last_ptr_i, wrapping modulo NREQ.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int PTR_W = clog2_min1(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] last_ptr_i,
   output logic [NREQ-1:0]  pick_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             valid_o
);

   int               cand;
   logic [PTR_W-1:0] cand_idx;

   // Walk from the farthest offset down to the nearest so the nearest hit wins.
   always_comb begin
      pick_o   = '0;
      idx_o    = '0;
      valid_o  = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = int'(last_ptr_i) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_idx = PTR_W'(cand);
         if (req_i[cand_idx]) begin
            pick_o           = '0;
            pick_o[cand_idx] = 1'b1;
            idx_o            = cand_idx;
            valid_o          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter driving one syncfifo write port from NREQ producers.
// Optional per-requester grant counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int BURST = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] data,
   output logic [NREQ-1:0]       grant,
   input  logic                  fifo_full,
   output logic                  fifo_wr_en,
   output logic [WIDTH-1:0]      fifo_in
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NREQ*STAT_W-1:0] grant_count
`endif
);

   localparam int PTR_W = clog2_min1(NREQ);
   localparam int CNT_W = clog2_min1(BURST + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

   arb_state_e       state_q, state_d;
   logic [PTR_W-1:0] last_ptr_q, last_ptr_d;
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

   logic [NREQ-1:0]  pick_vec;
   logic [PTR_W-1:0] pick_idx;
   logic             pick_vld;

   logic             gnt_vld;
   logic [PTR_W-1:0] gnt_idx;
   logic [NREQ-1:0]  gnt_vec;
   logic [WIDTH-1:0] slice [NREQ];

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_i      (req),
      .last_ptr_i (last_ptr_q),
      .pick_o     (pick_vec),
      .idx_o      (pick_idx),
      .valid_o    (pick_vld)
   );

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = data[gi*WIDTH +: WIDTH];
   end

   always_comb begin
      state_d    = state_q;
      last_ptr_d = last_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      gnt_vld    = 1'b0;
      gnt_idx    = owner_q;
      gnt_vec    = '0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_full && pick_vld) begin
               gnt_vld    = 1'b1;
               gnt_idx    = pick_idx;
               gnt_vec    = pick_vec;
               last_ptr_d = pick_idx;
               owner_d    = pick_idx;
               beat_cnt_d = CNT_W'(1);
               state_d    = (BURST > 1) ? S_BURST : S_IDLE;
            end
         end
         S_BURST: begin
            // A dropped owner request costs one bubble; a full FIFO just stalls the owner.
            if (!req[owner_q]) begin
               state_d = S_IDLE;
            end else if (!fifo_full) begin
               gnt_vld          = 1'b1;
               gnt_vec[owner_q] = 1'b1;
               beat_cnt_d       = beat_cnt_q + 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Gated by reset_n so outputs drop the moment reset asserts, not at the next edge.
   assign grant      = reset_n ? gnt_vec : '0;
   assign fifo_wr_en = reset_n & gnt_vld;
   assign fifo_in    = fifo_wr_en ? slice[gnt_idx] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         last_ptr_q <= PTR_W'(NREQ - 1);
         owner_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         last_ptr_q <= last_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
      logic [STAT_W-1:0] cnt_q;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q <= '0;
         end else if (grant[gi] && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
      assign grant_count[gi*STAT_W +: STAT_W] = cnt_q;
   end
`endif

endmodule
